cordic_shift_accumulate: RTL and testbench

One micro-rotation stage of the 16-stage pipelined CORDIC rotator (rotation mode). Each stage takes the running vector (x, y) and residual angle z, and applies a ±atan(2^-i) rotation using only shifts and adds. It registers the result, giving one clock of latency per stage. Instances `shift_accumulate0` … `shift_accumulate15` in the CORDIC top are this block with SHIFT = 0 … 15, chained back-to-back; the stage-i angle constant arrives on `tan`.

---
 rtl/cordic_shift_accumulate.sv | 58 +++++
 tb/tb_cordic_shift_accumulate.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_shift_accumulate.sv
// cordic_shift_accumulate: one rotation-mode CORDIC micro-rotation stage.
// Shift-and-add update of (x, y, z), registered with one clock of latency.
module cordic_shift_accumulate #(
    parameter int SHIFT = 0,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    input  logic [WIDTH-1:0] tan,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] z_out
);
    logic             w_neg;
    logic [WIDTH-1:0] w_xs;
    logic [WIDTH-1:0] w_ys;
    logic [WIDTH-1:0] w_x_nxt;
    logic [WIDTH-1:0] w_y_nxt;
    logic [WIDTH-1:0] w_z_nxt;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_z;

    // z = 0 rotates in the positive direction
    assign w_neg = z[WIDTH-1];
    assign w_xs  = $signed(x) >>> SHIFT;
    assign w_ys  = $signed(y) >>> SHIFT;

    always_comb begin
        w_x_nxt = x - w_ys;
        w_y_nxt = y + w_xs;
        w_z_nxt = z - tan;
        if (w_neg) begin
            w_x_nxt = x + w_ys;
            w_y_nxt = y - w_xs;
            w_z_nxt = z + tan;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
            r_z <= '0;
        end else begin
            r_x <= w_x_nxt;
            r_y <= w_y_nxt;
            r_z <= w_z_nxt;
        end
    end

    assign x_out = r_x;
    assign y_out = r_y;
    assign z_out = r_z;
endmodule

// File: tb/tb_cordic_shift_accumulate.sv
// tb_cordic_shift_accumulate: directed vectors, reset and a 16-stage chain
// checked against a stage model through an expected-result queue.
module tb_cordic_shift_accumulate;
    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
    } vec_t;

    localparam logic [31:0] TANS [0:15] = '{
        32'd51471, 32'd30385, 32'd16054, 32'd8149,
        32'd4090,  32'd2047,  32'd1023,  32'd511,
        32'd255,   32'd127,   32'd63,    32'd31,
        32'd15,    32'd7,     32'd3,     32'd1
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a_x = '0, a_y = '0, a_z = '0;
    logic [31:0] b_x = '0, b_y = '0, b_z = '0;
    logic [31:0] c_x = '0, c_y = '0, c_z = '0;
    logic [31:0] a_xo, a_yo, a_zo;
    logic [31:0] b_xo, b_yo, b_zo;
    logic [31:0] c_xo, c_yo, c_zo;
    logic [31:0] ch_x [0:16];
    logic [31:0] ch_y [0:16];
    logic [31:0] ch_z [0:16];
    logic [31:0] ch_tan [0:15];

    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];

    always #5 clk = ~clk;

    cordic_shift_accumulate #(.SHIFT(0), .WIDTH(32)) u_s0 (
        .clk(clk), .rst(rst), .x(a_x), .y(a_y), .z(a_z),
        .tan(32'd51471), .x_out(a_xo), .y_out(a_yo), .z_out(a_zo)
    );
    cordic_shift_accumulate #(.SHIFT(1), .WIDTH(32)) u_s1 (
        .clk(clk), .rst(rst), .x(b_x), .y(b_y), .z(b_z),
        .tan(32'd30385), .x_out(b_xo), .y_out(b_yo), .z_out(b_zo)
    );
    cordic_shift_accumulate #(.SHIFT(10), .WIDTH(32)) u_s10 (
        .clk(clk), .rst(rst), .x(c_x), .y(c_y), .z(c_z),
        .tan(32'd63), .x_out(c_xo), .y_out(c_yo), .z_out(c_zo)
    );

    for (genvar k = 0; k < 16; k++) begin : g_chain
        assign ch_tan[k] = TANS[k];
        cordic_shift_accumulate #(.SHIFT(k), .WIDTH(32)) u_st (
            .clk(clk), .rst(rst),
            .x(ch_x[k]), .y(ch_y[k]), .z(ch_z[k]), .tan(ch_tan[k]),
            .x_out(ch_x[k+1]), .y_out(ch_y[k+1]), .z_out(ch_z[k+1])
        );
    end

    function automatic vec_t stage_m(int sh, vec_t v, logic [31:0] t);
        vec_t        r;
        logic [31:0] xs;
        logic [31:0] ys;
        xs = $signed(v.x) >>> sh;
        ys = $signed(v.y) >>> sh;
        if (v.z[31]) begin
            r.x = v.x + ys;
            r.y = v.y - xs;
            r.z = v.z + t;
        end else begin
            r.x = v.x - ys;
            r.y = v.y + xs;
            r.z = v.z - t;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vec_t got;
        rst = 1'b1;
        a_x = 32'd12345; a_y = 32'd777; a_z = 32'd99;
        tick();
        got = '{a_xo, a_yo, a_zo};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_s0 got=%h want=0", got);
        end
        got = '{ch_x[16], ch_y[16], ch_z[16]};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_chain got=%h want=0", got);
        end
        for (int i = 0; i < 3; i++) begin
            a_x = $urandom; a_y = $urandom; a_z = $urandom;
            tick();
            got = '{a_xo, a_yo, a_zo};
            checks++;
            if (got !== '0) begin
                errors++;
                $display("FAIL reset_hold%0d got=%h want=0", i, got);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        vec_t got;
        vec_t exp;
        a_x = 32'd39797; a_y = 32'd0; a_z = 32'd0;
        b_x = 32'd65536; b_y = 32'd65536; b_z = -32'sd100;
        c_x = 32'hFFFFFC00; c_y = 32'd2048; c_z = 32'd5;
        tick();
        got = '{a_xo, a_yo, a_zo};
        exp = '{32'd39797, 32'd39797, 32'hFFFF36F1};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL vec_s0 got=%h want=%h", got, exp);
        end
        got = '{b_xo, b_yo, b_zo};
        exp = '{32'd98304, 32'd32768, 32'd30285};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL vec_s1 got=%h want=%h", got, exp);
        end
        got = '{c_xo, c_yo, c_zo};
        exp = '{-32'sd1026, 32'd2047, -32'sd58};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL vec_s10 got=%h want=%h", got, exp);
        end
        a_x = 32'h7FFFFFFF; a_y = 32'd1; a_z = 32'd0;
        tick();
        got = '{a_xo, a_yo, a_zo};
        exp = '{32'h7FFFFFFE, 32'h80000000, 32'hFFFF36F1};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL wrap_pos got=%h want=%h", got, exp);
        end
        a_z = 32'h80000000;
        tick();
        got = '{a_xo, a_yo, a_zo};
        exp = '{32'h80000000, 32'h80000002, 32'h8000C90F};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL wrap_neg got=%h want=%h", got, exp);
        end
    endtask

    task automatic test_back_to_back();
        vec_t got;
        vec_t exp;
        vec_t v;
        logic rb;
        for (int i = 0; i < 40; i++) begin
            rb = (i == 15) || (i >= 30 && i < 33);
            v = '{$urandom, $urandom, $urandom};
            a_x = v.x; a_y = v.y; a_z = v.z;
            rst = rb;
            sb.push_back(rb ? '0 : stage_m(0, v, 32'd51471));
            tick();
            exp = sb.pop_front();
            got = '{a_xo, a_yo, a_zo};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL b2b%0d got=%h want=%h", i, got, exp);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_chain();
        vec_t got;
        vec_t exp;
        vec_t v;
        vec_t m;
        int   n;
        n = 0;
        sb.delete();
        for (int i = 0; i < 40; i++) begin
            if (i == 0)
                v = '{32'd39797, 32'd0, 32'd34315};
            else
                v = '{32'd39797, 32'd0, $urandom_range(102942) - 32'd51471};
            ch_x[0] = v.x; ch_y[0] = v.y; ch_z[0] = v.z;
            m = v;
            for (int k = 0; k < 16; k++)
                m = stage_m(k, m, TANS[k]);
            sb.push_back(m);
            tick();
            if (i >= 15) begin
                exp = sb.pop_front();
                got = '{ch_x[16], ch_y[16], ch_z[16]};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL chain%0d got=%h want=%h", n, got, exp);
                end
                if (n == 0) begin
                    checks++;
                    if ($signed(got.x) < 56740 || $signed(got.x) > 56772) begin
                        errors++;
                        $display("FAIL chain_cos got=%0d want=56756+-16",
                                 $signed(got.x));
                    end
                    checks++;
                    if ($signed(got.y) < 32752 || $signed(got.y) > 32784) begin
                        errors++;
                        $display("FAIL chain_sin got=%0d want=32768+-16",
                                 $signed(got.y));
                    end
                end
                n++;
            end
        end
    endtask

    initial begin
        ch_x[0] = '0; ch_y[0] = '0; ch_z[0] = '0;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_chain();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
